// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// binary owner index and an optional hold timeout. The owner keeps the
// resource until it strobes done, drops its request, or hits MAX_HOLD
// consecutive cycles (MAX_HOLD = 0 disables the limit). A single idle
// cycle always separates two owners.
//
// Handshake: a requester holds req[i] high until it sees grant[i]; it keeps
// req[i] high for as long as it wants the resource and either pulses done
// or drops req[i] to release. No preemption: while an owner exists all
// other req bits are ignored.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic       HOLD_EN    = (MAX_HOLD != 0);

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic       grant_valid_q, grant_valid_d;
    logic       timeout_q, timeout_d;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic       release_norm;
    logic       expired;

    // Scan requests starting at the priority pointer, wrapping mod 4.
    always_comb begin
        logic [1:0] idx;
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        idx        = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    // Next-state logic for the IDLE/GRANT controller and its registered outputs.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_d        = hold_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        release_norm  = done || !req[grant_id_q];
        expired       = HOLD_EN && (hold_q == HOLD_LIMIT);

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d       = 4'b0001 << pick_idx;
                    grant_id_d    = pick_idx;
                    grant_valid_d = 1'b1;
                    hold_d        = 8'd1;
                    ptr_d         = pick_idx + 2'd1;
                    state_d       = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (release_norm || expired) begin
                    // grant_id intentionally keeps the last owner.
                    grant_d       = 4'b0000;
                    grant_valid_d = 1'b0;
                    hold_d        = 8'd0;
                    state_d       = ST_IDLE;
                    // A coinciding done/withdrawal counts as a normal release.
                    timeout_d     = expired && !release_norm;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 2'd0;
            hold_q        <= 8'd0;
            grant_q       <= 4'b0000;
            grant_id_q    <= 2'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_q        <= hold_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: dut_a uses MAX_HOLD=4, dut_b uses MAX_HOLD=0.
// Each step drives inputs, pushes the hand-derived outputs expected after
// the next edge, then pops and compares them 1 time unit after that edge.
module tb_rr_arbiter_4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, done_a, rst_b, done_b;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic [1:0] id_a, id_b;
  logic       valid_a, valid_b, to_a, to_b;

  rr_arbiter_4 #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .done(done_a),
    .grant(grant_a), .grant_id(id_a), .grant_valid(valid_a), .timeout(to_a)
  );

  rr_arbiter_4 #(.MAX_HOLD(0)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .done(done_b),
    .grant(grant_b), .grant_id(id_b), .grant_valid(valid_b), .timeout(to_b)
  );

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // sel=0 exercises dut_a (dut_b held in reset), sel=1 the reverse.
  task automatic step(input logic sel, input logic r, input logic [3:0] rq, input logic dn,
                      input logic [3:0] eg, input logic ev, input logic [1:0] eid,
                      input logic eto);
    logic [8:0] e;
    if (!sel) begin
      rst_a = r; req_a = rq; done_a = dn;
      rst_b = 1'b1; req_b = 4'b0; done_b = 1'b0;
    end else begin
      rst_b = r; req_b = rq; done_b = dn;
      rst_a = 1'b1; req_a = 4'b0; done_a = 1'b0;
    end
    exp_q.push_back({sel, eg, ev, eid, eto});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (!e[8]) begin
      check_eq("a_grant", {4'b0, grant_a}, {4'b0, e[7:4]});
      check_eq("a_valid", {7'b0, valid_a}, {7'b0, e[3]});
      check_eq("a_id",    {6'b0, id_a},    {6'b0, e[2:1]});
      check_eq("a_tout",  {7'b0, to_a},    {7'b0, e[0]});
    end else begin
      check_eq("b_grant", {4'b0, grant_b}, {4'b0, e[7:4]});
      check_eq("b_valid", {7'b0, valid_b}, {7'b0, e[3]});
      check_eq("b_id",    {6'b0, id_b},    {6'b0, e[2:1]});
      check_eq("b_tout",  {7'b0, to_b},    {7'b0, e[0]});
    end
  endtask

  initial begin
    logic [1:0] oid;
    logic [3:0] og;
    rst_a = 1'b1; req_a = 4'b0; done_a = 1'b0;
    rst_b = 1'b1; req_b = 4'b0; done_b = 1'b0;

    // 1. reset and single request
    step(0, 1, 4'b0000, rnd(), 4'b0000, 0, 2'd0, 0);
    step(0, 1, 4'b0000, rnd(), 4'b0000, 0, 2'd0, 0);
    step(0, 0, 4'b0000, rnd(), 4'b0000, 0, 2'd0, 0);
    step(0, 0, 4'b0100, rnd(), 4'b0100, 1, 2'd2, 0);
    check_eq("ptr_after_2", {6'b0, dut_a.ptr_q}, 8'd3);
    step(0, 0, 4'b0000, 0,     4'b0000, 0, 2'd2, 0);

    // 3. pointer wrap and skip (ptr=3)
    step(0, 0, 4'b0010, rnd(), 4'b0010, 1, 2'd1, 0);
    check_eq("ptr_after_1", {6'b0, dut_a.ptr_q}, 8'd2);
    step(0, 0, 4'b0010, 1,     4'b0000, 0, 2'd1, 0);
    step(0, 0, 4'b1001, rnd(), 4'b1000, 1, 2'd3, 0);
    step(0, 0, 4'b0000, 0,     4'b0000, 0, 2'd3, 0);

    // 2. rotation with req=1111, done on 3rd grant cycle (ptr=0)
    for (int i = 0; i < 5; i++) begin
      oid = 2'(i % 4);
      og  = 4'b0001 << oid;
      step(0, 0, 4'b1111, rnd(), og, 1, oid, 0);
      step(0, 0, 4'b1111, 0,     og, 1, oid, 0);
      step(0, 0, 4'b1111, 0,     og, 1, oid, 0);
      step(0, 0, 4'b1111, 1,     4'b0000, 0, oid, 0);
    end

    // 4. timeout with MAX_HOLD=4 (ptr=1, scan reaches 0)
    step(0, 0, 4'b0001, rnd(), 4'b0001, 1, 2'd0, 0);
    step(0, 0, 4'b0001, 0,     4'b0001, 1, 2'd0, 0);
    step(0, 0, 4'b0001, 0,     4'b0001, 1, 2'd0, 0);
    step(0, 0, 4'b0001, 0,     4'b0001, 1, 2'd0, 0);
    step(0, 0, 4'b0001, 0,     4'b0000, 0, 2'd0, 1);
    step(0, 0, 4'b0001, rnd(), 4'b0001, 1, 2'd0, 0);
    step(0, 0, 4'b0001, 0,     4'b0001, 1, 2'd0, 0);
    step(0, 0, 4'b0001, 0,     4'b0001, 1, 2'd0, 0);
    step(0, 0, 4'b0001, 0,     4'b0001, 1, 2'd0, 0);
    step(0, 0, 4'b0001, 1,     4'b0000, 0, 2'd0, 0);

    // 5. withdrawal and no preemption (ptr=1)
    step(0, 0, 4'b0010, rnd(), 4'b0010, 1, 2'd1, 0);
    step(0, 0, 4'b0011, 0,     4'b0010, 1, 2'd1, 0);
    step(0, 0, 4'b0011, 0,     4'b0010, 1, 2'd1, 0);
    step(0, 0, 4'b0001, 0,     4'b0000, 0, 2'd1, 0);
    step(0, 0, 4'b0001, rnd(), 4'b0001, 1, 2'd0, 0);
    // reset while granted clears everything including grant_id and ptr
    step(0, 1, 4'b0001, 0,     4'b0000, 0, 2'd0, 0);
    check_eq("ptr_reset", {6'b0, dut_a.ptr_q}, 8'd0);

    // 6. MAX_HOLD=0: long hold never times out, reset mid-grant
    step(1, 1, 4'b0000, rnd(), 4'b0000, 0, 2'd0, 0);
    step(1, 0, 4'b1000, rnd(), 4'b1000, 1, 2'd3, 0);
    for (int i = 0; i < 300; i++) begin
      step(1, 0, {1'b1, 3'($urandom_range(0, 7))}, 0, 4'b1000, 1, 2'd3, 0);
    end
    step(1, 1, 4'b1000, 0,     4'b0000, 0, 2'd0, 0);
    step(1, 0, 4'b1001, rnd(), 4'b0001, 1, 2'd0, 0);
    step(1, 0, 4'b1001, 1,     4'b0000, 0, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
